// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug blocks: default register-file geometry
// and the dump reader state encoding.
package cpu_dbg_pkg;

    localparam int ADDR_SIZE_DEF  = 5;
    localparam int DATA_WIDTH_DEF = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks every register-file address on a spare read port and streams each
// (address, data) pair over a valid/ready handshake to a debug sink.
module regfile_dump_reader
    import cpu_dbg_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_SIZE-1:0]  RA,
    input  logic [DATA_WIDTH-1:0] RD,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_SIZE-1:0]  dout_addr,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = {ADDR_SIZE{1'b1}};

    logic [1:0]            state, state_nxt;
    logic [ADDR_SIZE-1:0]  cnt, cnt_nxt;
    logic                  valid_nxt, busy_nxt, done_nxt;
    logic [ADDR_SIZE-1:0]  addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  hs;

    // A handshake that coincides with abort is discarded.
    assign hs = dout_valid && dout_ready && !abort;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dout_valid <= 1'b0;
            dout_addr  <= '0;
            dout_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dout_valid <= valid_nxt;
            dout_addr  <= addr_nxt;
            dout_data  <= data_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: state_nxt = abort ? IDLE : SEND;
            SEND: begin
                if (abort)
                    state_nxt = IDLE;
                else if (hs)
                    state_nxt = (cnt == LAST_ADDR) ? FIN : READ;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are computed here one cycle ahead; only RA is live.
    always_comb begin
        RA        = '0;
        cnt_nxt   = cnt;
        valid_nxt = dout_valid;
        addr_nxt  = dout_addr;
        data_nxt  = dout_data;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt  = '0;
                    busy_nxt = 1'b1;
                end
            end
            READ: begin
                RA = cnt;
                if (abort) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else begin
                    data_nxt  = RD;
                    addr_nxt  = cnt;
                    valid_nxt = 1'b1;
                end
            end
            SEND: begin
                RA = cnt;
                if (abort) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (hs) begin
                    valid_nxt = 1'b0;
                    if (cnt == LAST_ADDR) begin
                        done_nxt = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FIN: begin
                busy_nxt = 1'b0;
            end
            default: begin
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file
// that answers RA combinationally and takes CPU writes on the falling edge.
module tb_regfile_dump_reader;

    logic        CLK = 1'b0;
    logic        rst, start, abort, dout_ready;
    logic [4:0]  RA, dout_addr;
    logic [31:0] RD, dout_data;
    logic        dout_valid, busy, done;

    logic [31:0] rf [32];
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;

    assign RD = (RA == 5'd0) ? 32'h0 : rf[RA];

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (done === 1'b1) done_cnt <= done_cnt + 1;

    regfile_dump_reader #(.ADDR_SIZE(5), .DATA_WIDTH(32)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .RA         (RA),
        .RD         (RD),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_addr  (dout_addr),
        .dout_data  (dout_data),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [31:0] exp_d(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input int a, input logic [31:0] d);
        chk($sformatf("valid@%0d", a), 32'(dout_valid), 32'd1);
        chk($sformatf("addr@%0d", a), 32'(dout_addr), 32'(a));
        chk($sformatf("data@%0d", a), dout_data, d);
    endtask

    // Advance past the current word, then wait (bounded) for the next one.
    task automatic get_word(input int a, input logic [31:0] d);
        int k;
        k = 0;
        @(negedge CLK);
        while (dout_valid !== 1'b1 && k < 6) begin
            @(negedge CLK);
            k++;
        end
        chk_word(a, d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_RA"},    32'(RA), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        #2;
        chk_idle_outputs("rst");
        chk("rst_addr", 32'(dout_addr), 32'd0);
        chk("rst_data", dout_data, 32'd0);
        @(negedge CLK);
        rst = 1'b0;

        // Full dump with ready held high: exact cadence and done timing.
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_valid", 32'(dout_valid), 32'd0);
        chk("lat_RA", 32'(RA), 32'd0);
        @(negedge CLK);
        chk_word(0, 32'h0);
        for (int i = 1; i < 32; i++) begin
            @(negedge CLK);
            chk($sformatf("gap@%0d", i), 32'(dout_valid), 32'd0);
            @(negedge CLK);
            chk_word(i, exp_d(i));
        end
        @(negedge CLK);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_valid", 32'(dout_valid), 32'd0);
        @(negedge CLK);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("done_cnt1", 32'(done_cnt), 32'd1);

        // Backpressure, concurrent CPU writes, start while busy.
        pulse_start();
        get_word(0, 32'h0);
        get_word(1, exp_d(1));
        get_word(2, exp_d(2));
        rf[2] = 32'h0BAD_0002;
        #1 chk("r2_after_capture", dout_data, 32'h1000_0002);
        @(negedge CLK);
        dout_ready = 1'b0;
        chk("bp_gap", 32'(dout_valid), 32'd0);
        @(negedge CLK);
        for (int j = 0; j < 5; j++) begin
            chk_word(3, 32'h1000_0003);
            if (j < 4) @(negedge CLK);
        end
        dout_ready = 1'b1;
        get_word(4, exp_d(4));
        get_word(5, exp_d(5));
        get_word(6, exp_d(6));
        @(negedge CLK);
        chk("RA_read7", 32'(RA), 32'd7);
        rf[7] = 32'hDEAD_BEEF;
        get_word(7, 32'hDEAD_BEEF);
        rf[7] = 32'h1234_5678;
        #1 chk("r7_after_capture", dout_data, 32'hDEAD_BEEF);
        get_word(8, exp_d(8));
        get_word(9, exp_d(9));
        get_word(10, exp_d(10));
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_after_restart_try", 32'(busy), 32'd1);
        rf[2] = exp_d(2);
        rf[7] = exp_d(7);
        for (int i = 11; i < 32; i++) get_word(i, exp_d(i));
        @(negedge CLK);
        chk("fin2_done", 32'(done), 32'd1);
        chk("fin2_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge CLK);
        chk("fin_start_ignored", 32'(busy), 32'd0);
        chk("fin2_done_low", 32'(done), 32'd0);
        chk("done_cnt2", 32'(done_cnt), 32'd2);
        @(negedge CLK);
        start = 1'b0;
        chk("start_after_fin", 32'(busy), 32'd1);

        // Abort during SEND at address 15, then restart from 0.
        for (int i = 0; i < 16; i++) get_word(i, exp_d(i));
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk_idle_outputs("abort");
        @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk_idle_outputs("abort_idle");
        chk("done_cnt_abort", 32'(done_cnt), 32'd2);
        pulse_start();
        for (int i = 0; i < 21; i++) get_word(i, exp_d(i));

        // Asynchronous reset between clock edges at address 20.
        #3 rst = 1'b1;
        #1;
        chk_idle_outputs("arst");
        chk("arst_addr", 32'(dout_addr), 32'd0);
        chk("arst_data", dout_data, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        chk_idle_outputs("arst_rel");
        chk("done_cnt_arst", 32'(done_cnt), 32'd2);

        // Clean dump after reset.
        pulse_start();
        for (int i = 0; i < 32; i++) get_word(i, exp_d(i));
        @(negedge CLK);
        chk("fin4_done", 32'(done), 32'd1);
        @(negedge CLK);
        chk("done_cnt4", 32'(done_cnt), 32'd3);
        chk("end_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
